// File: rtl/max_pkg.sv
// Shared constants and state encoding for the max-pool capture buffer.
package max_pkg;

    localparam int DATA_W = 33;
    localparam int DEPTH  = 576;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2,
        ST_READ    = 2'd3
    } state_e;

endpackage

// File: rtl/max_buf_ram.sv
// Frame buffer: simple dual-port RAM, one write and one synchronous read port.
module max_buf_ram #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 576,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/max_data_collect.sv
// Captures one frame from the max-pool generator, then replays it on a
// valid/ready port through a 2-entry skid behind the 1-cycle RAM read.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for arm; valid input is flagged as overflow
//   CAPTURE | writing qualified words at wr_count until DEPTH are stored
//   FULL    | complete frame held; rd_start begins a replay
//   READ    | streaming words 0..DEPTH-1, back to FULL after rd_last
module max_data_collect
    import max_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    output logic              gen_start,
    input  logic              data_in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              frame_done,
    output logic              buf_full,
    output logic [ADDR_W-1:0] wr_count,
    output logic              overflow_err,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic              gen_start_q;
    logic              frame_done_q;
    logic              buf_full_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] wr_count_q;
    logic [ADDR_W-1:0] iss_idx_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [DATA_W-1:0] skid_data_q [2];
    logic [1:0]        skid_last_q;
    logic              skid_rp_q;
    logic              skid_wp_q;
    logic [1:0]        skid_cnt_q;

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              push;
    logic              pop;
    logic [1:0]        occ_after_pop;

    assign gen_start    = gen_start_q;
    assign frame_done   = frame_done_q;
    assign buf_full     = buf_full_q;
    assign wr_count     = wr_count_q;
    assign overflow_err = overflow_q;
    assign rd_valid     = (skid_cnt_q != 2'd0);
    assign rd_data      = skid_data_q[skid_rp_q];
    assign rd_last      = skid_last_q[skid_rp_q];

    assign push          = inflight_q;
    assign pop           = rd_valid && rd_ready;
    assign occ_after_pop = skid_cnt_q + 2'(inflight_q) - 2'(pop);
    assign wr_en         = !abort && (state_q == ST_CAPTURE) && data_in_valid;

    // Word 0 is fetched in the rd_start cycle so it lands in the skid one
    // cycle later; afterwards a fetch is issued only if its data has a slot.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = iss_idx_q;
        if (!abort) begin
            if ((state_q == ST_FULL) && rd_start) begin
                rd_en   = 1'b1;
                rd_addr = '0;
            end else if ((state_q == ST_READ) && (iss_idx_q != DEPTH_A) &&
                         (occ_after_pop <= 2'd1)) begin
                rd_en = 1'b1;
            end
        end
    end

    max_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_count_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            gen_start_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            buf_full_q      <= 1'b0;
            overflow_q      <= 1'b0;
            wr_count_q      <= '0;
            iss_idx_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            skid_data_q[0]  <= '0;
            skid_data_q[1]  <= '0;
            skid_last_q     <= '0;
            skid_rp_q       <= 1'b0;
            skid_wp_q       <= 1'b0;
            skid_cnt_q      <= '0;
        end else begin
            gen_start_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            inflight_q      <= rd_en;
            inflight_last_q <= (rd_addr == LAST_A);
            if (rd_en) begin
                iss_idx_q <= rd_addr + ADDR_W'(1);
            end
            if (push) begin
                skid_data_q[skid_wp_q] <= ram_rd_data;
                skid_last_q[skid_wp_q] <= inflight_last_q;
                skid_wp_q              <= ~skid_wp_q;
            end
            if (pop) begin
                skid_rp_q <= ~skid_rp_q;
            end
            skid_cnt_q <= skid_cnt_q + 2'(push) - 2'(pop);

            if (abort) begin
                state_q    <= ST_IDLE;
                buf_full_q <= 1'b0;
                wr_count_q <= '0;
                inflight_q <= 1'b0;
                skid_rp_q  <= 1'b0;
                skid_wp_q  <= 1'b0;
                skid_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arm) begin
                            state_q     <= ST_CAPTURE;
                            gen_start_q <= 1'b1;
                            wr_count_q  <= '0;
                            overflow_q  <= 1'b0;
                        end else if (data_in_valid) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (data_in_valid) begin
                            wr_count_q <= wr_count_q + ADDR_W'(1);
                            if (wr_count_q == LAST_A) begin
                                frame_done_q <= 1'b1;
                                buf_full_q   <= 1'b1;
                                state_q      <= ST_FULL;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (data_in_valid) begin
                            overflow_q <= 1'b1;
                        end
                        if (rd_start) begin
                            state_q <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        if (data_in_valid) begin
                            overflow_q <= 1'b1;
                        end
                        if (pop && rd_last) begin
                            state_q <= ST_FULL;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max_data_collect.sv
// Self-checking bench for max_data_collect: control table plus frame-level
// capture/replay sequences checked against an expected-frame array.
module tb_max_data_collect;
    import max_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              arm;
    logic              abort;
    logic              gen_start;
    logic              data_in_valid;
    logic [DATA_W-1:0] data_in;
    logic              frame_done;
    logic              buf_full;
    logic [ADDR_W-1:0] wr_count;
    logic              overflow_err;
    logic              rd_start;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DATA_W-1:0] exp_frame [DEPTH];

    typedef struct {
        logic arm;
        logic abort;
        logic rd_start;
        logic valid;
        logic e_gen;
        logic e_full;
        logic e_ovf;
        int   e_wrc;
    } vec_t;

    vec_t tbl [13];

    max_data_collect dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .abort         (abort),
        .gen_start     (gen_start),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .frame_done    (frame_done),
        .buf_full      (buf_full),
        .wr_count      (wr_count),
        .overflow_err  (overflow_err),
        .rd_start      (rd_start),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_last       (rd_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [DATA_W-1:0] r;
        r[31:0] = $urandom;
        r[32]   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gen_start"}, 64'(gen_start), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_buf_full"}, 64'(buf_full), 64'd0);
        chk({tag, "_wr_count"}, 64'(wr_count), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow_err), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        chk({tag, "_rd_last"}, 64'(rd_last), 64'd0);
    endtask

    // Arm from IDLE with a valid word in the same cycle: neither captured nor flagged.
    task automatic start_capture();
        arm           = 1'b1;
        data_in_valid = 1'b1;
        data_in       = rnd_word();
        tick();
        arm           = 1'b0;
        data_in_valid = 1'b0;
        chk("arm_gen_start", 64'(gen_start), 64'd1);
        chk("arm_wr_count", 64'(wr_count), 64'd0);
        chk("arm_overflow", 64'(overflow_err), 64'd0);
        chk("arm_buf_full", 64'(buf_full), 64'd0);
    endtask

    // gap_mode: 0 back-to-back, 1 alternating 1,0,..., 2 random.
    task automatic capture(input int gap_mode, input bit rand_data, input int nwords);
        int w   = 0;
        int cyc = 0;
        logic v;
        while (w < nwords && cyc < 8 * DEPTH) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            data_in_valid = v;
            data_in       = v ? (rand_data ? rnd_word() : DATA_W'(w)) : rnd_word();
            if (v) exp_frame[w] = data_in;
            tick();
            if (v) w++;
            cyc++;
            chk("cap_wr_count", 64'(wr_count), 64'(w));
            chk("cap_frame_done", 64'(frame_done), 64'(v && (w == DEPTH)));
            chk("cap_buf_full", 64'(buf_full), 64'(w == DEPTH));
            chk("cap_gen_start", 64'(gen_start), 64'd0);
        end
        data_in_valid = 1'b0;
        chk("cap_timeout", 64'(w), 64'(nwords));
        if (nwords == DEPTH) begin
            tick();
            chk("cap_frame_done_drop", 64'(frame_done), 64'd0);
            chk("cap_full_hold", 64'(buf_full), 64'd1);
            chk("cap_wr_count_sat", 64'(wr_count), 64'(DEPTH));
        end
    endtask

    // mode 0: rd_ready held high (no bubbles allowed); mode 1: random ready.
    task automatic read_frame(input int mode);
        int idx = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [DATA_W-1:0] held = '0;
        rd_start = 1'b1;
        rd_ready = (mode == 0);
        tick();
        rd_start = 1'b0;
        chk("rd_lat1_valid", 64'(rd_valid), 64'd0);
        tick();
        chk("rd_lat2_valid", 64'(rd_valid), 64'd1);
        while (idx < DEPTH && cyc < 6 * DEPTH) begin
            if (rd_valid) begin
                chk("rd_data", 64'(rd_data), 64'(exp_frame[idx]));
                chk("rd_last", 64'(rd_last), 64'(idx == DEPTH - 1));
                if (stalled) chk("rd_stall_hold", 64'(rd_data), 64'(held));
                rd_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                stalled  = !rd_ready;
                held     = rd_data;
                if (rd_ready) idx++;
            end else begin
                if (mode == 0) chk("rd_no_bubble", 64'(rd_valid), 64'd1);
                if (stalled) chk("rd_stall_valid", 64'(rd_valid), 64'd1);
                stalled  = 1'b0;
                rd_ready = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_timeout", 64'(idx), 64'(DEPTH));
        chk("rd_end_valid", 64'(rd_valid), 64'd0);
        chk("rd_end_full", 64'(buf_full), 64'd1);
    endtask

    // Read part of a frame, then abort (how=0) or pull reset (how=1).
    task automatic partial_read(input int how);
        int idx = 0;
        rd_start = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (rd_valid) begin
                chk("prd_data", 64'(rd_data), 64'(exp_frame[idx]));
                rd_ready = 1'($urandom_range(0, 1));
                if (rd_ready) idx++;
            end
            tick();
        end
        rd_ready = 1'b0;
        if (how == 0) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_rd_valid", 64'(rd_valid), 64'd0);
            chk("abort_rd_full", 64'(buf_full), 64'd0);
            chk("abort_rd_wr_count", 64'(wr_count), 64'd0);
        end else begin
            #2 rst_n = 1'b0;
            #1;
            chk_all_zero("rst_mid_read");
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            chk_all_zero("after_rst");
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        arm           = 1'b0;
        abort         = 1'b0;
        rd_start      = 1'b0;
        rd_ready      = 1'b0;
        data_in_valid = 1'b0;
        data_in       = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk_all_zero("reset");

        //         arm  abt  rds  vld   gen  full ovf  wrc
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1, 0};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 2};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 3};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1, 0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1, 0};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 0};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};

        for (int i = 0; i < 13; i++) begin
            arm           = tbl[i].arm;
            abort         = tbl[i].abort;
            rd_start      = tbl[i].rd_start;
            data_in_valid = tbl[i].valid;
            data_in       = rnd_word();
            tick();
            chk($sformatf("tbl%0d_gen_start", i), 64'(gen_start), 64'(tbl[i].e_gen));
            chk($sformatf("tbl%0d_buf_full", i), 64'(buf_full), 64'(tbl[i].e_full));
            chk($sformatf("tbl%0d_overflow", i), 64'(overflow_err), 64'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_wr_count", i), 64'(wr_count), 64'(tbl[i].e_wrc));
            chk($sformatf("tbl%0d_rd_valid", i), 64'(rd_valid), 64'd0);
            chk($sformatf("tbl%0d_frame_done", i), 64'(frame_done), 64'd0);
        end
        arm = 1'b0; abort = 1'b0; rd_start = 1'b0; data_in_valid = 1'b0;
        tick();

        // Contiguous frame of 0..575, arm ignored while FULL, then two replays.
        start_capture();
        capture(0, 1'b0, DEPTH);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("full_arm_gen_start", 64'(gen_start), 64'd0);
        chk("full_arm_buf_full", 64'(buf_full), 64'd1);
        chk("full_arm_wr_count", 64'(wr_count), 64'(DEPTH));
        read_frame(0);
        read_frame(1);

        // Alternating-valid capture of the same pattern.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start_capture();
        capture(1, 1'b0, DEPTH);
        read_frame(0);

        // Word arriving in FULL is flagged and dropped.
        data_in_valid = 1'b1;
        data_in       = 33'h1_0000_0001;
        tick();
        data_in_valid = 1'b0;
        chk("ovf_set", 64'(overflow_err), 64'd1);
        read_frame(1);
        chk("ovf_sticky", 64'(overflow_err), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ovf_kept_by_abort", 64'(overflow_err), 64'd1);
        chk("abort_full", 64'(buf_full), 64'd0);

        // Abort after 100 words, then a full random frame.
        start_capture();
        capture(0, 1'b1, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cap_wr_count", 64'(wr_count), 64'd0);
        chk("abort_cap_full", 64'(buf_full), 64'd0);
        chk("abort_cap_frame_done", 64'(frame_done), 64'd0);
        chk("abort_cap_gen_start", 64'(gen_start), 64'd0);
        start_capture();
        capture(2, 1'b1, DEPTH);
        read_frame(1);
        partial_read(0);

        // Reset in the middle of a readout, then a normal recapture.
        start_capture();
        capture(2, 1'b1, DEPTH);
        partial_read(1);
        start_capture();
        capture(0, 1'b1, DEPTH);
        read_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/max_data_collect.md
Name: max_data_collect

Overview:
- Capture end of the max-pool data stream. Pulses a one-cycle start request to the upstream generator, then captures DEPTH words of 33-bit data qualified by data_in_valid into an internal buffer.
- Once the buffer is full, replays the frame in order on a valid/ready read port.
- Sits between the max-data generator and downstream consumers: FC-layer feed, or the test readback path.

Parameters:
- DATA_W, 33, width of each captured word.
- DEPTH, 576, words per frame.
- ADDR_W, 10, buffer address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  one-cycle pulse; starts a capture when in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- gen_start  output  1  one-cycle pulse to the upstream generator's data_start.
- data_in_valid  input  1  qualifies data_in.
- data_in  input  DATA_W  captured word.
- frame_done  output  1  one-cycle pulse when word DEPTH-1 is written.
- buf_full  output  1  level; buffer holds a complete frame.
- wr_count  output  ADDR_W  words captured in the current frame.
- overflow_err  output  1  sticky; a valid word arrived while not in CAPTURE.
- rd_start  input  1  one-cycle pulse; starts readout when in FULL.
- rd_valid  output  1  rd_data valid.
- rd_ready  input  1  downstream accepts rd_data.
- rd_data  output  DATA_W  readout word.
- rd_last  output  1  high with the final word (index DEPTH-1).

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; overflow_err 0. Buffer contents are not reset.
- States:
  - IDLE: on arm, go to CAPTURE, pulse gen_start in the same cycle it registers (1 cycle after arm), clear wr_count to 0.
  - CAPTURE:
    - Each cycle with data_in_valid=1, write data_in at wr_count and increment wr_count.
    - Gaps (valid=0) are allowed, with no timeout.
    - When the word at index DEPTH-1 is written, frame_done pulses the following cycle, buf_full goes to 1 and the state goes to FULL.
  - FULL:
    - Holds the frame.
    - arm is ignored.
    - On rd_start, go to READ and set rd_idx to 0.
  - READ:
    - Streams words 0..DEPTH-1 in order.
    - First rd_valid appears 2 cycles after rd_start.
    - A transfer happens when rd_valid && rd_ready.
    - With rd_ready held high, one word per cycle with no bubbles.
    - When rd_ready=0, rd_valid/rd_data/rd_last hold stable.
    - After the transfer with rd_last=1, return to FULL: buf_full stays 1 and the frame can be re-read.
- Leaving FULL: arm while in FULL is ignored. To recapture, issue abort and then arm.
- abort: in any state, the next cycle is IDLE. rd_valid, buf_full, frame_done and gen_start drop to 0; wr_count clears to 0. overflow_err is kept.
- Priority: abort > arm/rd_start > data_in_valid.
- arm in CAPTURE or READ is ignored. rd_start outside FULL is ignored.
- overflow_err:
  - Set when data_in_valid=1 in IDLE, FULL or READ. The word is dropped, never written.
  - Cleared only by reset or by arm accepted in IDLE.
  - Valid on the same cycle as an accepted arm is not captured (the capture starts next cycle) and not flagged.
- Buffer: simple dual-port, 1 write port and 1 read port, synchronous read with 1-cycle latency. The readout uses a 2-entry skid so that full throughput holds under back-pressure.
- wr_count saturates at DEPTH; it never wraps.

Decomposition:
- Shared package max_pkg: DATA_W=33, DEPTH=576, ADDR_W=10, state encoding (IDLE, CAPTURE, FULL, READ).
- One sub-module, max_buf_ram: DEPTH x DATA_W simple dual-port RAM, synchronous read, no reset on the array.

Test Plan:
- Reset then arm: gen_start pulses once 1 cycle later. Drive 576 consecutive valid words 0..575. Expect frame_done pulse the cycle after word 575, buf_full=1, wr_count=576.
- Gapped input: the same 576 words with valid toggling 1,0,1,0. Expect identical capture; frame_done only after the 576th valid.
- Readout with rd_ready=1 after rd_start: rd_valid begins 2 cycles later. Expect 576 consecutive beats with data 0..575; rd_last only on data 575.
- Back-pressure: rd_ready random with 50% duty. Expect in-order 0..575, data stable while stalled, no duplicates or drops. A second rd_start replays the same frame.
- Overflow: valid word 0x1_0000_0001 while in FULL. Expect overflow_err=1, the buffer unchanged on readout, and the flag cleared by abort followed by arm.
- Abort mid-capture after 100 words, then rst_n low mid-READ. Expect IDLE next cycle with all outputs 0. A new arm capture completes normally.
